// File: rtl/axi_burst_mem.sv
// AXI-style burst memory: independent read and write FSMs sharing one storage array.
// Define AXI_BURST_MEM_STALL_EN to enable LFSR-driven stall injection on both channels.
module axi_burst_mem #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [1:0]              arburst,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rlast,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int unsigned STRB = DATA_WIDTH / 8;
  localparam int unsigned OFFS = $clog2(STRB);
  localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = a >> OFFS;
    return IW'(w % ADDR_WIDTH'(DEPTH));
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx,
                                             input logic [7:0]    len,
                                             input logic [1:0]    burst);
    logic [IW-1:0] mask;
    mask = IW'(len);
    case (burst)
      2'b00:   return idx;
      2'b10:   return (idx & ~mask) | ((idx + 1'b1) & mask);
      default: return (idx == IW'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endcase
  endfunction

  logic stall;
`ifdef AXI_BURST_MEM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{wlast, 1'b0};

  // ---------------- read channel ----------------
  r_state_t              r_state, r_next;
  logic [IW-1:0]         r_idx, r_idx_nxt;
  logic [7:0]            r_len, r_beat;
  logic [1:0]            r_burst;
  logic [CW-1:0]         r_cnt;
  logic                  r_rv, ar_hs, r_hs, r_last_beat;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign arready     = (r_state == R_IDLE);
  assign ar_hs       = arvalid && arready;
  assign rvalid      = r_rv;
  assign r_hs        = r_rv && rready;
  assign r_last_beat = (r_beat == r_len);
  assign rlast       = r_rv && r_last_beat;
  assign rdata       = rdata_q;
  assign r_idx_nxt   = next_idx(r_idx, r_len, r_burst);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_WAIT;
      R_WAIT:  if (r_cnt == '0 && !stall) r_next = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // r_rv can only drop inside R_DATA after a handshake, so a presented beat is never withdrawn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_rv    <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_idx   <= word_idx(araddr);
          r_len   <= arlen;
          r_burst <= arburst;
          r_beat  <= '0;
          r_cnt   <= CW'(RD_LATENCY - 1);
        end
        R_WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else if (!stall) begin
            rdata_q <= mem[r_idx];
            r_rv    <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (r_last_beat) r_rv <= 1'b0;
            else begin
              r_idx  <= r_idx_nxt;
              r_beat <= r_beat + 8'd1;
              if (stall) r_rv <= 1'b0;
              else       rdata_q <= mem[r_idx_nxt];
            end
          end else if (!r_rv && !stall) begin
            rdata_q <= mem[r_idx];
            r_rv    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- write channel ----------------
  w_state_t      w_state, w_next;
  logic [IW-1:0] w_idx;
  logic [7:0]    w_len, w_beat;
  logic [1:0]    w_burst;
  logic          bvalid_q, aw_hs, w_hs, w_last_beat;

  assign awready     = (w_state == W_IDLE);
  assign aw_hs       = awvalid && awready;
  assign wready      = (w_state == W_DATA) && !stall;
  assign w_hs        = wvalid && wready;
  assign w_last_beat = (w_beat == w_len);
  assign bvalid      = bvalid_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (bvalid_q && bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_idx    <= '0;
      w_len    <= '0;
      w_burst  <= '0;
      w_beat   <= '0;
      bvalid_q <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          w_idx   <= word_idx(awaddr);
          w_len   <= awlen;
          w_burst <= awburst;
          w_beat  <= '0;
        end
        W_DATA: if (w_hs && !w_last_beat) begin
          w_idx  <= next_idx(w_idx, w_len, w_burst);
          w_beat <= w_beat + 8'd1;
        end
        W_RESP: begin
          if (!bvalid_q)   bvalid_q <= 1'b1;
          else if (bready) bvalid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Storage is never reset; reads above sample the pre-write value on a same-edge write.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int unsigned b = 0; b < STRB; b++) begin
        if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: doc/axi_burst_mem.md
AXI_BURST_MEM -- requirements
Module: axi_burst_mem

Interface
REQ-001 Parameters SHALL be as listed below, one per line: name, default, meaning.
- DATA_WIDTH, 128, data bus width in bits; power of two, 32 to 512.
- ADDR_WIDTH, 64, byte address width.
- DEPTH, 64, storage depth in DATA_WIDTH-bit words.
- RD_LATENCY, 2, cycles from the AR handshake to the first rvalid; minimum 1.

REQ-002 Ports SHALL be as listed below, one per line: name, direction, width, meaning.
- clk  in  1  clock; single clock domain.
- rstn  in  1  asynchronous, active-low reset.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- araddr  in  ADDR_WIDTH  read start byte address.
- arlen  in  8  read beats minus one.
- arburst  in  2  read burst type.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- rdata  out  DATA_WIDTH  read data.
- rlast  out  1  final read beat.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- awaddr  in  ADDR_WIDTH  write start byte address.
- awlen  in  8  write beats minus one.
- awburst  in  2  write burst type.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  write byte enables.
- wlast  in  1  final write beat.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

Function
REQ-003 The block SHALL hold storage array `mem[0:DEPTH-1]` of DATA_WIDTH bits, hierarchically accessible for backdoor load and check.
REQ-004 The word index SHALL be (addr >> log2(DATA_WIDTH/8)) mod DEPTH; the low address bits SHALL be ignored. Every beat is full-width.
REQ-005 Burst addressing SHALL be: FIXED (00) no increment; INCR (01) +1 word per beat, wrapping modulo DEPTH; WRAP (10) wraps within an aligned (len+1)-word block, with len restricted to 1, 3, 7 or 15; reserved (11) SHALL be treated as INCR.
REQ-006 The read FSM SHALL have states R_IDLE, R_WAIT and R_DATA.
- arready=1 only in R_IDLE.
- An AR handshake SHALL move the FSM to R_WAIT for RD_LATENCY cycles, then to R_DATA.
- rvalid SHALL be 1 in R_DATA.
- rdata and rlast SHALL be held stable while rvalid=1 and rready=0.
- rlast SHALL assert on beat arlen.
- The rlast handshake SHALL return the FSM to R_IDLE.
REQ-007 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
- awready=1 only in W_IDLE.
- wready=1 only in W_DATA.
- Each W handshake SHALL write the bytes whose wstrb bit is 1; bytes with wstrb=0 SHALL be unchanged.
- The handshake on beat awlen SHALL move the FSM to W_RESP; wlast SHALL be ignored for counting.
- bvalid SHALL assert the cycle after entry to W_RESP and hold until bready=1, then return the FSM to W_IDLE.
REQ-008 The read and write FSMs SHALL operate concurrently. A same-cycle read and write of the same word SHALL return the pre-write data.
REQ-009 Write data SHALL be visible to a read that is issued after bvalid.

Reset
REQ-010 With rstn=0, the block SHALL force both FSMs to IDLE and drive arready=1, awready=1, rvalid=0, wready=0, bvalid=0, rlast=0 and rdata=0, including when reset arrives mid-burst.
REQ-011 Reset SHALL NOT modify `mem`.

Configuration
REQ-012 With macro AXI_BURST_MEM_STALL_EN defined, a 16-bit LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, stepping every cycle) SHALL stall the block whenever lfsr[1:0]==00:
- wready is forced to 0.
- A new read beat is not presented; an rvalid that is already asserted SHALL never drop before its handshake.
REQ-013 With the macro undefined, the block SHALL insert no stalls, and throughput SHALL be one beat per cycle.

Verification
REQ-014 Backdoor mem[4..11]=k; INCR read at araddr=0x40, arlen=7, rready=1 -> 8 beats returning k=4..11, first rvalid RD_LATENCY cycles after the AR handshake, rlast on beat 8 only.
REQ-015 WRAP read at araddr=0x60, arlen=3 -> words 6, 7, 4, 5, in that order.
REQ-016 mem[12]=0; write with wdata all ones and wstrb=16'h00FF -> mem[12]=64'h0 in the upper half and all ones in the lower half; bready held 0 for 3 cycles -> bvalid stays 1 throughout.
REQ-017 FIXED write at word 2, 4 beats of data 1, 2, 3, 4 -> mem[2]=4, mem[3] unchanged.
REQ-018 Assert rstn=0 after beat 3 of an 8-beat read -> rvalid=0 immediately, arready=1 after release, mem unchanged; a subsequent read completes correctly.
